// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a one-cycle synchronous imem, and presents
// PC/instruction/valid to decode one cycle after the address. Stalls hold the IF/ID word; redirects kill it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        misalign_err,
  output logic        oob_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        hold_q, hold_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        misalign_q, misalign_d;
  logic        oob_q, oob_d;
  logic [31:0] count_q, count_d;
  logic        pc_in_range;

  assign imem_addr    = {2'b00, pc_q[31:2]};
  assign pc_in_range  = imem_addr < IMEM_WORDS_W;
  assign id_instr     = hold_q ? hold_instr_q : imem_data;
  assign id_pc        = rsp_pc_q;
  assign id_pc_plus4  = rsp_pc_q + 32'd4;
  assign id_valid     = rsp_valid_q;
  assign misalign_err = misalign_q;
  assign oob_err      = oob_q;
  assign fetch_count  = count_q;

  always_comb begin
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    rsp_valid_d  = rsp_valid_q;
    hold_d       = hold_q;
    hold_instr_d = hold_instr_q;
    misalign_d   = misalign_q;
    oob_d        = oob_q;
    count_d      = count_q;

    if (redirect_valid) begin
      // The word currently in flight belongs to the wrong path and is dropped.
      pc_d        = {redirect_target[31:2], 2'b00};
      rsp_valid_d = 1'b0;
      hold_d      = 1'b0;
      if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (stall) begin
      // Memory keeps re-reading pc_q, so capture the word decode is looking at.
      hold_d       = 1'b1;
      hold_instr_d = id_instr;
    end else begin
      hold_d = 1'b0;
      if (pc_in_range) begin
        pc_d        = pc_q + 32'd4;
        rsp_pc_d    = pc_q;
        rsp_valid_d = 1'b1;
      end else begin
        rsp_valid_d = 1'b0;
        oob_d       = 1'b1;
      end
    end

    if (rsp_valid_q && !stall && !redirect_valid) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      rsp_pc_q     <= 32'd0;
      rsp_valid_q  <= 1'b0;
      hold_q       <= 1'b0;
      hold_instr_q <= 32'd0;
      misalign_q   <= 1'b0;
      oob_q        <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      rsp_valid_q  <= rsp_valid_d;
      hold_q       <= hold_d;
      hold_instr_q <= hold_instr_d;
      misalign_q   <= misalign_d;
      oob_q        <= oob_d;
      count_q      <= count_d;
    end
  end

endmodule
